// File: rtl/pll_rst_seq.sv
// PLL reset sequencer: pulses the PLL reset, qualifies lock, then releases downstream resets one by one.
// Optional feature: define PLL_RST_SEQ_STATUS_EN to add the lost_cnt lock-loss counter output.
module pll_rst_seq #(
    parameter int N_CH         = 3,
    parameter int PLL_RST_CYC  = 16,
    parameter int LOCK_STABLE  = 1024,
    parameter int LOCK_TIMEOUT = 65536,
    parameter int STAGGER      = 8,
    parameter int MAX_RETRY    = 4
) (
    input  logic            clkin,
    input  logic            reset,
    input  logic            lock,
    output logic            pll_reset,
    output logic [N_CH-1:0] rst_out,
    output logic            ready,
    output logic            fail
`ifdef PLL_RST_SEQ_STATUS_EN
    ,
    output logic [7:0]      lost_cnt
`endif
);

    // Zero-length phases are treated as one cycle so every compare below stays in range.
    localparam int P_RST = (PLL_RST_CYC  < 1) ? 1 : PLL_RST_CYC;
    localparam int P_STB = (LOCK_STABLE  < 1) ? 1 : LOCK_STABLE;
    localparam int P_TMO = (LOCK_TIMEOUT < 1) ? 1 : LOCK_TIMEOUT;
    localparam int P_STG = (STAGGER      < 1) ? 1 : STAGGER;
    localparam int T_A   = (P_RST > P_STB) ? P_RST : P_STB;
    localparam int T_B   = (P_TMO > P_STG) ? P_TMO : P_STG;
    localparam int T_MAX = (T_A > T_B) ? T_A : T_B;
    localparam int TW    = $clog2(T_MAX + 1);

    localparam int RETRY_SAT = (MAX_RETRY > 0) ? MAX_RETRY : 1;
    localparam int RW        = $clog2(RETRY_SAT + 1);

    localparam logic [N_CH-1:0] ALL_ONES = '1;

    typedef enum logic [2:0] {S_PRST, S_WAIT, S_STAB, S_REL, S_RUN, S_FAIL} state_t;

    state_t          r_state;
    logic            r_lock_meta;
    logic            r_lock_s;
    logic [TW-1:0]   r_timer;
    logic [RW-1:0]   r_retry;
    logic            r_pll_reset;
    logic [N_CH-1:0] r_rst_out;
    logic            r_ready;
    logic            r_fail;

    logic            w_lock_lost;
    logic [TW-1:0]   w_timer_inc;
    logic [RW-1:0]   w_retry_inc;

    assign w_lock_lost = ((r_state == S_REL) || (r_state == S_RUN)) && !r_lock_s;
    assign w_timer_inc = (r_timer == TW'(T_MAX))     ? r_timer : r_timer + TW'(1);
    assign w_retry_inc = (r_retry == RW'(RETRY_SAT)) ? r_retry : r_retry + RW'(1);

    // NOTE: every flop here uses <= so all registers update from the same pre-edge values.
    always_ff @(posedge clkin) begin
        if (reset) begin
            r_lock_meta <= 1'b0;
            r_lock_s    <= 1'b0;
        end else begin
            r_lock_meta <= lock;
            r_lock_s    <= r_lock_meta;
        end
    end

    always_ff @(posedge clkin) begin
        if (reset) begin
            r_state     <= S_PRST;
            r_timer     <= '0;
            r_retry     <= '0;
            r_pll_reset <= 1'b1;
            r_rst_out   <= ALL_ONES;
            r_ready     <= 1'b0;
            r_fail      <= 1'b0;
        end else if (w_lock_lost) begin
            // Lock loss beats any stagger release due on the same edge.
            r_state     <= S_PRST;
            r_timer     <= '0;
            r_pll_reset <= 1'b1;
            r_rst_out   <= ALL_ONES;
            r_ready     <= 1'b0;
        end else begin
            case (r_state)
                S_PRST: begin
                    if (r_timer == TW'(P_RST - 1)) begin
                        r_state     <= S_WAIT;
                        r_timer     <= '0;
                        r_pll_reset <= 1'b0;
                    end else begin
                        r_timer <= w_timer_inc;
                    end
                end
                S_WAIT: begin
                    if (r_lock_s) begin
                        r_state <= S_STAB;
                        r_timer <= '0;
                    end else if (r_timer == TW'(P_TMO - 1)) begin
                        r_retry     <= w_retry_inc;
                        r_timer     <= '0;
                        r_pll_reset <= 1'b1;
                        if ((MAX_RETRY != 0) && (w_retry_inc == RW'(MAX_RETRY))) begin
                            r_state <= S_FAIL;
                            r_fail  <= 1'b1;
                        end else begin
                            r_state <= S_PRST;
                        end
                    end else begin
                        r_timer <= w_timer_inc;
                    end
                end
                S_STAB: begin
                    if (!r_lock_s) begin
                        r_state <= S_WAIT;
                        r_timer <= '0;
                    end else if (r_timer == TW'(P_STB - 1)) begin
                        r_state   <= S_REL;
                        r_timer   <= '0;
                        r_rst_out <= ALL_ONES << 1;
                    end else begin
                        r_timer <= w_timer_inc;
                    end
                end
                S_REL: begin
                    // Channels release in index order, so a zero-filling shift clears the next one.
                    if (r_rst_out == '0) begin
                        r_state <= S_RUN;
                        r_ready <= 1'b1;
                        r_retry <= '0;
                    end else if (r_timer == TW'(P_STG - 1)) begin
                        r_rst_out <= r_rst_out << 1;
                        r_timer   <= '0;
                    end else begin
                        r_timer <= w_timer_inc;
                    end
                end
                S_RUN: begin
                    r_ready <= 1'b1;
                end
                S_FAIL: begin
                    r_pll_reset <= 1'b1;
                    r_rst_out   <= ALL_ONES;
                    r_ready     <= 1'b0;
                    r_fail      <= 1'b1;
                end
                default: begin
                    r_state <= S_PRST;
                    r_timer <= '0;
                end
            endcase
        end
    end

`ifdef PLL_RST_SEQ_STATUS_EN
    logic [7:0] r_lost_cnt;

    always_ff @(posedge clkin) begin
        if (reset) begin
            r_lost_cnt <= '0;
        end else if (w_lock_lost && (r_lost_cnt != 8'hFF)) begin
            r_lost_cnt <= r_lost_cnt + 8'd1;
        end
    end

    assign lost_cnt = r_lost_cnt;
`endif

    assign pll_reset = r_pll_reset;
    assign rst_out   = r_rst_out;
    assign ready     = r_ready;
    assign fail      = r_fail;

endmodule

// File: tb/tb_pll_rst_seq.sv
// Bench for pll_rst_seq: directed scenarios then random lock activity, every cycle compared
// against a phase/elapsed-time reference model. Covers lost_cnt when PLL_RST_SEQ_STATUS_EN is defined.
module tb_pll_rst_seq;

    localparam int N_CH         = 3;
    localparam int PLL_RST_CYC  = 4;
    localparam int LOCK_STABLE  = 8;
    localparam int LOCK_TIMEOUT = 32;
    localparam int STAGGER      = 3;
    localparam int MAX_RETRY    = 2;

    logic            clkin = 1'b0;
    logic            reset = 1'b1;
    logic            lock  = 1'b0;
    logic            pll_reset;
    logic [N_CH-1:0] rst_out;
    logic            ready;
    logic            fail;
`ifdef PLL_RST_SEQ_STATUS_EN
    logic [7:0]      lost_cnt;
`endif

    int    vectors     = 0;
    int    miscompares = 0;
    string tag         = "reset";

    always #5 clkin = ~clkin;

    pll_rst_seq #(
        .N_CH        (N_CH),
        .PLL_RST_CYC (PLL_RST_CYC),
        .LOCK_STABLE (LOCK_STABLE),
        .LOCK_TIMEOUT(LOCK_TIMEOUT),
        .STAGGER     (STAGGER),
        .MAX_RETRY   (MAX_RETRY)
    ) u_dut (
        .clkin    (clkin),
        .reset    (reset),
        .lock     (lock),
        .pll_reset(pll_reset),
        .rst_out  (rst_out),
        .ready    (ready),
        .fail     (fail)
`ifdef PLL_RST_SEQ_STATUS_EN
        ,
        .lost_cnt (lost_cnt)
`endif
    );

    // Reference model: current phase plus the edge number it was entered on.
    typedef enum {M_PRST, M_WAIT, M_STAB, M_REL, M_RUN, M_FAIL} mphase_t;

    mphase_t m_phase   = M_PRST;
    int      m_cyc     = 0;
    int      m_t0      = 0;
    int      m_retries = 0;
    int      m_lost    = 0;
    logic    m_sync1   = 1'b0;
    logic    m_sync2   = 1'b0;

    task automatic enter(input mphase_t p);
        m_phase = p;
        m_t0    = m_cyc;
    endtask

    task automatic model_edge(input logic rst, input logic lk);
        logic ls;
        int   el;
        m_cyc++;
        ls = m_sync2;
        el = m_cyc - m_t0;
        if (rst) begin
            m_sync1   = 1'b0;
            m_sync2   = 1'b0;
            m_retries = 0;
            m_lost    = 0;
            enter(M_PRST);
            return;
        end
        m_sync2 = m_sync1;
        m_sync1 = lk;
        case (m_phase)
            M_PRST: if (el == PLL_RST_CYC) enter(M_WAIT);
            M_WAIT: begin
                if (ls) enter(M_STAB);
                else if (el == LOCK_TIMEOUT) begin
                    m_retries++;
                    enter((MAX_RETRY != 0 && m_retries == MAX_RETRY) ? M_FAIL : M_PRST);
                end
            end
            M_STAB: begin
                if (!ls) enter(M_WAIT);
                else if (el == LOCK_STABLE) enter(M_REL);
            end
            M_REL: begin
                if (!ls) begin
                    m_lost++;
                    enter(M_PRST);
                end else if (el == (N_CH - 1) * STAGGER + 1) begin
                    m_retries = 0;
                    enter(M_RUN);
                end
            end
            M_RUN: begin
                if (!ls) begin
                    m_lost++;
                    enter(M_PRST);
                end
            end
            default: ;
        endcase
    endtask

    // Channel i is released once i*STAGGER cycles have passed since REL entry.
    function automatic logic [N_CH-1:0] exp_rst_out();
        logic [N_CH-1:0] v = '1;
        if (m_phase == M_RUN) v = '0;
        else if (m_phase == M_REL)
            for (int i = 0; i < N_CH; i++)
                if (m_cyc - m_t0 >= i * STAGGER) v[i] = 1'b0;
        return v;
    endfunction

    task automatic step();
        logic [N_CH+2:0] exp_v;
        logic [N_CH+2:0] got_v;
        @(posedge clkin);
        model_edge(reset, lock);
        #1;
        exp_v = {(m_phase == M_PRST) || (m_phase == M_FAIL), exp_rst_out(),
                 (m_phase == M_RUN), (m_phase == M_FAIL)};
        got_v = {pll_reset, rst_out, ready, fail};
        vectors++;
        assert (got_v === exp_v) else begin
            miscompares++;
            $error("FAIL %s cyc=%0d {pll_reset,rst_out,ready,fail} observed=%b expected=%b",
                   tag, m_cyc, got_v, exp_v);
        end
`ifdef PLL_RST_SEQ_STATUS_EN
        vectors++;
        assert (lost_cnt === ((m_lost > 255) ? 8'd255 : 8'(m_lost))) else begin
            miscompares++;
            $error("FAIL %s_lost_cnt cyc=%0d observed=%0d expected=%0d", tag, m_cyc, lost_cnt, m_lost);
        end
`endif
    endtask

    task automatic run_until(input mphase_t target, input int budget);
        int n = 0;
        while (m_phase != target && n < budget) begin
            step();
            n++;
        end
        if (m_phase != target) begin
            vectors++;
            miscompares++;
            $error("FAIL %s_timeout observed=%s expected=%s after %0d cycles",
                   tag, m_phase.name(), target.name(), budget);
        end
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    initial begin
        // Reset values, held over several edges.
        reset = 1'b1;
        lock  = 1'b0;
        repeat (3) step();

        // Clean bring-up with lock high from the start.
        tag   = "bringup";
        reset = 1'b0;
        lock  = 1'b1;
        run_until(M_RUN, 200);
        repeat (5) step();

        // Lock loss in RUN, then recovery.
        tag  = "run_loss";
        lock = 1'b0;
        repeat (3) step();
        lock = 1'b1;
        run_until(M_RUN, 200);
        repeat (3) step();

        // One-cycle lock glitch in the middle of stabilisation.
        tag = "stab_glitch";
        pulse_reset();
        run_until(M_STAB, 200);
        repeat (4) step();
        lock = 1'b0;
        step();
        lock = 1'b1;
        run_until(M_RUN, 300);

        // Reset while channels are being released.
        tag = "reset_mid_rel";
        pulse_reset();
        run_until(M_REL, 200);
        step();
        pulse_reset();
        run_until(M_RUN, 200);

        // Lock loss landing on the same edge as the second channel release.
        tag = "loss_vs_stagger";
        pulse_reset();
        run_until(M_REL, 200);
        lock = 1'b0;
        repeat (6) step();
        lock = 1'b1;
        run_until(M_RUN, 200);

        // No lock at all: retries exhaust and FAIL is sticky until reset.
        tag  = "timeout";
        lock = 1'b0;
        pulse_reset();
        run_until(M_FAIL, 300);
        repeat (10) step();
        lock = 1'b1;
        repeat (20) step();
        pulse_reset();
        run_until(M_RUN, 200);

        // Random lock activity with occasional resets.
        tag = "random";
        for (int burst = 0; burst < 150; burst++) begin
            int len;
            lock = 1'($urandom_range(0, 3) != 0);
            len  = lock ? $urandom_range(1, 60) : $urandom_range(1, 12);
            if ($urandom_range(0, 29) == 0) pulse_reset();
            for (int c = 0; c < len; c++) step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/pll_rst_seq.md
PLL_RST_SEQ -- requirements
Module: pll_rst_seq

Interface
REQ-001 SHALL have parameter N_CH, default 3, range 1..8: number of downstream reset channels.
REQ-002 SHALL have parameter PLL_RST_CYC, default 16: clkin cycles pll_reset is held per attempt.
REQ-003 SHALL have parameter LOCK_STABLE, default 1024: cycles synchronized lock must stay high before release.
REQ-004 SHALL have parameter LOCK_TIMEOUT, default 65536: cycles allowed in WAIT for lock before retry.
REQ-005 SHALL have parameter STAGGER, default 8: cycles between successive channel releases.
REQ-006 SHALL have parameter MAX_RETRY, default 4: failed attempts before FAIL; 0 = retry forever.
REQ-007 SHALL have port clkin, input, 1: sole clock, free-running reference.
REQ-008 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-009 SHALL have port lock, input, 1: PLL LOCK, asynchronous to clkin.
REQ-010 SHALL have port pll_reset, output, 1: drives PLL RESET, active-high.
REQ-011 SHALL have port rst_out, output, N_CH: per-domain resets, active-high.
REQ-012 SHALL have port ready, output, 1: all channels released, lock good.
REQ-013 SHALL have port fail, output, 1: retry budget exhausted.

Function
REQ-014 SHALL pass lock through a 2-FF synchronizer (lock_s); all decisions use lock_s only.
REQ-015 SHALL implement states PRST, WAIT, STAB, REL, RUN, FAIL; all outputs registered.
REQ-016 PRST: pll_reset=1, rst_out all 1; after exactly PLL_RST_CYC cycles -> WAIT, pll_reset=0.
REQ-017 WAIT: lock_s=1 -> STAB; timer reaches LOCK_TIMEOUT -> retry_cnt+1, then PRST (or FAIL if MAX_RETRY!=0 and retry_cnt==MAX_RETRY).
REQ-018 STAB: lock_s=0 -> WAIT with timeout timer cleared; LOCK_STABLE consecutive lock_s=1 cycles -> REL.
REQ-019 REL: release rst_out[0] on REL entry, rst_out[i] exactly i*STAGGER cycles later; after rst_out[N_CH-1] clears -> RUN.
REQ-020 RUN: ready=1; retry_cnt cleared on RUN entry.
REQ-021 In REL or RUN, lock_s=0 SHALL on the next edge set all rst_out=1, ready=0, enter PRST.
REQ-022 Lock loss and a stagger release in the same cycle: lock loss wins; no further bit clears.
REQ-023 FAIL: pll_reset=1, rst_out all 1, ready=0, fail=1; exits only on reset.
REQ-024 Counters SHALL be sized by $clog2 of their max parameter +1 and SHALL saturate, never wrap.
REQ-025 N_CH=1: REL lasts one cycle; STAGGER has no effect.

Reset
REQ-026 reset=1 at any clkin edge, mid-operation included, SHALL force PRST with timers and retry_cnt cleared.
REQ-027 Reset values: pll_reset=1, rst_out all 1, ready=0, fail=0, lost_cnt=0.
REQ-028 Synchronizer flops SHALL reset to 0.

Configuration
REQ-029 Macro PLL_RST_SEQ_STATUS_EN defined: adds output lost_cnt [7:0], incremented on each REL/RUN lock-loss event, saturating at 255, cleared only by reset.
REQ-030 Macro undefined: lost_cnt port and logic absent; all other behaviour identical.

Verification (PLL_RST_CYC=4, LOCK_STABLE=8, LOCK_TIMEOUT=32, STAGGER=3, MAX_RETRY=2, N_CH=3)
REQ-031 Release reset; lock=1 from cycle 0 -> pll_reset low after 4 cycles; rst_out 111->110->100->000 at 3-cycle spacing; ready=1.
REQ-032 In STAB, lock low 1 cycle at count 5 -> stays in WAIT/STAB, full 8 stable cycles re-required before any rst_out bit clears.
REQ-033 lock held 0 -> two 32-cycle timeouts, pll_reset pulses twice, then fail=1, pll_reset=1, rst_out=111 held.
REQ-034 In RUN, drop lock -> within 3 cycles (2 sync + 1) rst_out=111, ready=0, pll_reset=1 for 4 cycles; lost_cnt=1 with macro.
REQ-035 Assert reset mid-REL (rst_out=110) -> next edge rst_out=111, pll_reset=1, sequence restarts from PRST.
